sel_seq_mult: RTL and testbench

- Sequential shift-add multiplier. Counterpart to the combinational select-divider (A/B, B/C, C/D, D/A with divide-by-zero error).
- Selects an operand pair from four WIDTH-bit inputs using the same rotation and multiplies them over WIDTH cycles.
- Reports the full product, a truncated WIDTH-bit result, and an overflow error flag (the multiplicative dual of divide-by-zero).
- Start/done handshake so a controller or testbench can sequence operations.

---
 rtl/sel_seq_mult.sv | 121 ++++++++++++
 tb/tb_sel_seq_mult.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sel_seq_mult.sv
// Sequential shift-add multiplier with rotating operand-pair select.
//
// Picks one of four operand pairs (A*B, B*C, C*D, D*A) on an accepted start,
// then adds one shifted partial product per cycle for WIDTH cycles. The full
// 2*WIDTH-bit product, its low half and an overflow flag (upper half nonzero)
// are registered on the final iteration and held until the next result.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    operation request, sampled only in IDLE or DONE
//   A..D     WIDTH-bit unsigned operands
//   select   pair select: 00=A*B, 01=B*C, 10=C*D, 11=D*A
//   busy     high while iterating (exactly WIDTH cycles)
//   done     one-cycle pulse when product/out/error are fresh
//   product  full 2*WIDTH-bit product
//   out      product[WIDTH-1:0]
//   error    product[2*WIDTH-1:WIDTH] != 0
module sel_seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   C,
  input  logic [WIDTH-1:0]   D,
  input  logic [1:0]         select,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   out,
  output logic               error
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] product_q;
  logic               error_q;

  logic [WIDTH-1:0]   op_first;
  logic [WIDTH-1:0]   op_second;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_d;

  // Operand pair rotation: first operand becomes the multiplicand.
  always_comb begin
    op_first  = A;
    op_second = B;
    unique case (select)
      2'b00: begin op_first = A; op_second = B; end
      2'b01: begin op_first = B; op_second = C; end
      2'b10: begin op_first = C; op_second = D; end
      2'b11: begin op_first = D; op_second = A; end
      default: ;
    endcase
  end

  // Multiplier is shifted right each step, so its LSB is the current bit;
  // the multiplicand stays put and is shifted by the iteration count instead.
  always_comb begin
    addend = '0;
    if (mplier_q[0]) begin
      addend = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
    end
    acc_d = acc_q + addend;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      error_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            mcand_q  <= op_first;
            mplier_q <= op_second;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            product_q <= acc_d;
            error_q   <= |acc_d[2*WIDTH-1:WIDTH];
            state_q   <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign product = product_q;
  assign out     = product_q[WIDTH-1:0];
  assign error   = error_q;

endmodule

// File: tb/tb_sel_seq_mult.sv
// Scoreboard bench for sel_seq_mult: stimulus pushes hand-computed results
// with the cycle their done pulse is due; a monitor pops on every done.
module tb_sel_seq_mult;

  localparam int unsigned W = 8;

  typedef struct {
    logic [2*W-1:0] prod;
    logic [W-1:0]   low;
    logic           err;
    int unsigned    due;
  } exp_t;

  logic           clk = 1'b0;
  logic           clk_en = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   A = '0, B = '0, C = '0, D = '0;
  logic [1:0]     select = '0;
  logic           busy, done, error;
  logic [2*W-1:0] product;
  logic [W-1:0]   out;

  int unsigned cyc = 0;
  int unsigned n_total = 0;
  int unsigned n_pass = 0;
  int unsigned busy_run = 0;
  exp_t        sb[$];

  sel_seq_mult #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D),
    .select (select),
    .busy   (busy),
    .done   (done),
    .product(product),
    .out    (out),
    .error  (error)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Drive a request for one cycle; acc returns the cycle index of the accept edge.
  task automatic issue(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d,
                       output int unsigned acc);
    @(negedge clk);
    select = sel; A = a; B = b; C = c; D = d;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    acc    = cyc;
  endtask

  task automatic expect_res(input logic [2*W-1:0] p, input logic [W-1:0] lo, input logic e,
                            input int unsigned due);
    exp_t x;
    x.prod = p; x.low = lo; x.err = e; x.due = due;
    sb.push_back(x);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("product", 32'(product), 32'(x.prod));
        check("out", 32'(out), 32'(x.low));
        check("error", 32'(error), 32'(x.err));
        check("done_cycle", cyc, x.due);
        check("busy_cycles", busy_run, W);
        check("busy_with_done", 32'(busy), 32'd0);
      end
    end
    if (busy) busy_run = busy_run + 1;
    else busy_run = 0;
  end

  initial begin
    int unsigned acc;
    int unsigned acc2;

    // Asynchronous reset with the clock stopped.
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    #4 rst = 1'b0;
    clk_en = 1'b1;
    repeat (2) @(negedge clk);

    // 15 * 2
    issue(2'b00, 8'd15, 8'd2, 8'd0, 8'd0, acc);
    expect_res(16'd30, 8'd30, 1'b0, acc + W);
    repeat (11) @(negedge clk);

    // B*C = 20 * 13 = 260
    issue(2'b01, 8'd0, 8'd20, 8'd13, 8'd0, acc);
    expect_res(16'h0104, 8'h04, 1'b1, acc + W);
    repeat (11) @(negedge clk);

    // D*A = 255 * 255
    issue(2'b11, 8'd255, 8'd0, 8'd0, 8'd255, acc);
    expect_res(16'hFE01, 8'h01, 1'b1, acc + W);
    repeat (11) @(negedge clk);

    // C*D with zero operand
    issue(2'b10, 8'd0, 8'd0, 8'd0, 8'd200, acc);
    expect_res(16'd0, 8'd0, 1'b0, acc + W);
    repeat (11) @(negedge clk);

    // 7 * 9, with input changes and a start pulse while running
    issue(2'b00, 8'd7, 8'd9, 8'd0, 8'd0, acc);
    expect_res(16'd63, 8'd63, 1'b0, acc + W);
    repeat (2) @(negedge clk);
    A = 8'd100; select = 2'b11; D = 8'd77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Raise start in the last RUN cycle and hold it through DONE.
    for (int i = 0; i < 20 && cyc < acc + W - 1; i++) @(negedge clk);
    select = 2'b01; B = 8'd3; C = 8'd5;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    acc2 = cyc;
    check("b2b_accept", acc2, acc + W + 1);
    expect_res(16'd15, 8'd15, 1'b0, acc2 + W);
    repeat (2) @(negedge clk);
    check("hold_product", 32'(product), 32'd63);
    repeat (10) @(negedge clk);

    // Reset four cycles into a 255*255 run: no done, outputs cleared at once.
    issue(2'b11, 8'd255, 8'd0, 8'd0, 8'd255, acc);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_product", 32'(product), 32'd0);
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_rst", 32'(busy), 32'd0);

    // Fresh operation after reset: 12 * 11
    issue(2'b00, 8'd12, 8'd11, 8'd0, 8'd0, acc);
    expect_res(16'd132, 8'd132, 1'b0, acc + W);
    repeat (14) @(negedge clk);

    check("pending_results", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
